// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a FETCH / ISSUE (/ HALT) state machine.
// Holds one fetched instruction for decode and redirects on jr, j/jal and
// taken branches, with priority jump_reg > jump > branch_taken. A redirect that
// arrives while a memory request is outstanding is parked. The word that comes
// back for that request is dropped, and fetch restarts at the parked target.
// Optional feature macro: HALT_DETECT_EN. When it is defined, consuming the word
// 32'hFFFF_FFFF stops fetch until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        halted
);

`ifdef HALT_DETECT_EN
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_ISSUE = 2'd1, S_HALT = 2'd2} state_t;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
`else
    typedef enum logic [1:0] {S_FETCH = 2'd0, S_ISSUE = 2'd1} state_t;
`endif

    // Fetch addresses are always word aligned, including the reset address.
    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;          // current / next fetch address
    logic [31:0] instr_q, instr_d;        // held instruction
    logic [31:0] pc_q, pc_d;              // address of the held instruction
    logic        pend_q, pend_d;          // a redirect is parked during FETCH
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        redirect;
    logic [31:0] target;

    assign pc_plus4 = pc_q + 32'd4;

    // Redirect target selection: jump_reg > jump > branch_taken, with the low two bits forced to zero
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        redirect = jump_reg | jump | branch_taken;
        target   = {branch_target[31:2], 2'b00};
        if (jump_reg) begin
            target = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            target = {pc_plus4[31:28], jump_index, 2'b00};
        end
    end

    // State register, fetch datapath and parked redirect, all with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples its pre-edge inputs.
        if (rst) begin
            state_q     <= S_FETCH;
            addr_q      <= RESET_ADDR;
            instr_q     <= 32'd0;
            pc_q        <= RESET_ADDR;
            pend_q      <= 1'b0;
            pend_addr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready && !pend_q && !redirect) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
`ifdef HALT_DETECT_EN
                    state_d = (instr_q == HALT_WORD) ? S_HALT : S_FETCH;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef HALT_DETECT_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Datapath next values: capture, discard or park a redirect, and advance on consume
    always_comb begin
        addr_d      = addr_q;
        instr_d     = instr_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    if (pend_q || redirect) begin
                        // A stale word returns: drop it and refetch at the newest target.
                        addr_d = redirect ? target : pend_addr_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = addr_q;
                    end
                end else if (redirect) begin
                    // Keep imem_addr stable; only the parked target moves.
                    pend_d      = 1'b1;
                    pend_addr_d = target;
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    addr_d = redirect ? target : pc_plus4;
                end
            end
            default: ;
        endcase
    end

    // Output decode
    always_comb begin
        imem_req    = (state_q == S_FETCH) && !rst;
        imem_addr   = addr_q;
        instr       = instr_q;
        opcode      = instr_q[31:26];
        instr_valid = (state_q == S_ISSUE);
        pc_out      = pc_q;
`ifdef HALT_DETECT_EN
        halted      = (state_q == S_HALT);
`else
        halted      = 1'b0;
`endif
    end

endmodule
